// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_pkg: shared types and helpers for the forwarding/hazard unit.
//   fwd_sel_t : operand source encoding (RF, E, M, W)
//   fwd_rec_t : in-flight destination record {wa, tnew}
//   sat_dec   : saturating decrement used as a record ages from E to M
// Records use fixed maximum widths (REC_AW, REC_TW). Module parameters
// AW/TW must not exceed these. Narrower values are zero-extended into a record.
package fwd_pkg;

  localparam int REC_AW = 8;
  localparam int REC_TW = 4;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic [REC_AW-1:0] wa;
    logic [REC_TW-1:0] tnew;
  } fwd_rec_t;

  function automatic logic [REC_TW-1:0] sat_dec(input logic [REC_TW-1:0] t);
    return (t == '0) ? '0 : t - REC_TW'(1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: bundle of every signal exchanged between the pipeline
// and the forwarding/hazard unit.
//   D-stage requests : d_rs_addr, d_tuse, d_rf_data, d_wa, d_tnew, d_md
//   producer results : e_fwd_data, m_fwd_data, w_fwd_data
//   mult/div control : e_md_start, e_md_div
//   results          : fwd_data, fwd_sel, fwd_pending, stall, md_busy
// Modports:
//   master : the pipeline side (drives requests, reads results)
//   slave  : the hazard unit side
interface fwd_hazard_unit_if #(
  parameter int DW  = 32,
  parameter int NCH = 2,
  parameter int AW  = 5,
  parameter int TW  = 2
);
  logic [NCH*AW-1:0] d_rs_addr;
  logic [NCH*TW-1:0] d_tuse;
  logic [NCH*DW-1:0] d_rf_data;
  logic [AW-1:0]     d_wa;
  logic [TW-1:0]     d_tnew;
  logic              d_md;
  logic              e_md_start;
  logic              e_md_div;
  logic [DW-1:0]     e_fwd_data;
  logic [DW-1:0]     m_fwd_data;
  logic [DW-1:0]     w_fwd_data;
  logic [NCH*DW-1:0] fwd_data;
  logic [NCH*2-1:0]  fwd_sel;
  logic [NCH-1:0]    fwd_pending;
  logic              stall;
  logic              md_busy;

  modport master (
    output d_rs_addr, d_tuse, d_rf_data, d_wa, d_tnew, d_md,
    output e_md_start, e_md_div, e_fwd_data, m_fwd_data, w_fwd_data,
    input  fwd_data, fwd_sel, fwd_pending, stall, md_busy
  );

  modport slave (
    input  d_rs_addr, d_tuse, d_rf_data, d_wa, d_tnew, d_md,
    input  e_md_start, e_md_div, e_fwd_data, m_fwd_data, w_fwd_data,
    output fwd_data, fwd_sel, fwd_pending, stall, md_busy
  );

endinterface

// File: rtl/fwd_hazard_unit_chan_resolve.sv
// fwd_chan_resolve: resolves one D-stage read channel against the E/M/W
// in-flight records. Purely combinational.
//   e_rec/m_rec/w_rec : in-flight destination records
//   addr, tuse        : source register and cycles until it is consumed
//   rf_data           : register-file read data for this channel
//   e/m/w_data        : forwardable results of each stage
//   data, sel         : resolved operand and its source
//   pending           : the producer is not ready yet, but will be before use
//   stall             : the producer cannot be ready in time
module fwd_chan_resolve
  import fwd_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int TW = 2
) (
  input  fwd_rec_t         e_rec,
  input  fwd_rec_t         m_rec,
  input  fwd_rec_t         w_rec,
  input  logic [AW-1:0]    addr,
  input  logic [TW-1:0]    tuse,
  input  logic [DW-1:0]    rf_data,
  input  logic [DW-1:0]    e_data,
  input  logic [DW-1:0]    m_data,
  input  logic [DW-1:0]    w_data,
  output logic [DW-1:0]    data,
  output fwd_sel_t         sel,
  output logic             pending,
  output logic             stall
);

  logic             hit;
  fwd_rec_t         hit_rec;
  fwd_sel_t         hit_sel;
  logic [DW-1:0]    hit_data;
  logic [REC_AW-1:0] addr_ext;

  assign addr_ext = REC_AW'(addr);

  // Youngest producer wins: E, then M, then W. Register 0 never matches,
  // which also keeps empty (wa==0) records from matching.
  always_comb begin
    hit      = 1'b0;
    hit_rec  = '0;
    hit_sel  = FWD_RF;
    hit_data = rf_data;
    if (addr_ext != '0) begin
      if (e_rec.wa == addr_ext) begin
        hit = 1'b1; hit_rec = e_rec; hit_sel = FWD_E; hit_data = e_data;
      end else if (m_rec.wa == addr_ext) begin
        hit = 1'b1; hit_rec = m_rec; hit_sel = FWD_M; hit_data = m_data;
      end else if (w_rec.wa == addr_ext) begin
        hit = 1'b1; hit_rec = w_rec; hit_sel = FWD_W; hit_data = w_data;
      end
    end
  end

  // A producer still tnew cycles away is tolerable if the consumer needs the
  // value no sooner than that; a later stage re-resolves it then.
  always_comb begin
    data    = rf_data;
    sel     = FWD_RF;
    pending = 1'b0;
    stall   = 1'b0;
    if (hit) begin
      if (hit_rec.tnew == '0) begin
        data = hit_data;
        sel  = hit_sel;
      end else if (hit_rec.tnew <= REC_TW'(tuse)) begin
        pending = 1'b1;
      end else begin
        stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks destination registers in flight in E, M and W and,
// for NCH D-stage read channels, selects forwarded operands or requests a stall.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : fwd_hazard_unit_if.slave (requests in, operands/stall out)
// Optional feature, macro FWD_MD_STALL_EN: a mult/div busy counter that stalls
// any D instruction using the mult/div unit while it is busy or starting.
// Without the macro md_busy is 0 and d_md/e_md_start/e_md_div are ignored.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DW       = 32,
  parameter int NCH      = 2,
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic              clk,
  input logic              reset_n,
  fwd_hazard_unit_if.slave bus
);

  fwd_rec_t       e_rec, m_rec, w_rec;
  logic [DW-1:0]  ch_data    [NCH];
  fwd_sel_t       ch_sel     [NCH];
  logic           ch_pending [NCH];
  logic           ch_stall   [NCH];
  logic           chan_stall;
  logic           md_stall;
  logic           md_busy_int;
  logic           stall_int;

  // Records age one stage per clock. A stalled D instruction is replaced by
  // a bubble in E; anything reaching W is by definition already produced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_rec <= '0;
      m_rec <= '0;
      w_rec <= '0;
    end else begin
      w_rec <= '{wa: m_rec.wa, tnew: '0};
      m_rec <= '{wa: e_rec.wa, tnew: sat_dec(e_rec.tnew)};
      if (stall_int) begin
        e_rec <= '0;
      end else begin
        e_rec <= '{wa: REC_AW'(bus.d_wa), tnew: REC_TW'(bus.d_tnew)};
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    fwd_chan_resolve #(.DW(DW), .AW(AW), .TW(TW)) u_resolve (
      .e_rec   (e_rec),
      .m_rec   (m_rec),
      .w_rec   (w_rec),
      .addr    (bus.d_rs_addr[g*AW +: AW]),
      .tuse    (bus.d_tuse[g*TW +: TW]),
      .rf_data (bus.d_rf_data[g*DW +: DW]),
      .e_data  (bus.e_fwd_data),
      .m_data  (bus.m_fwd_data),
      .w_data  (bus.w_fwd_data),
      .data    (ch_data[g]),
      .sel     (ch_sel[g]),
      .pending (ch_pending[g]),
      .stall   (ch_stall[g])
    );
  end

  // Pack per-channel results onto the flat bus vectors.
  always_comb begin
    bus.fwd_data    = '0;
    bus.fwd_sel     = '0;
    bus.fwd_pending = '0;
    chan_stall      = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      bus.fwd_data[i*DW +: DW] = ch_data[i];
      bus.fwd_sel[i*2 +: 2]    = ch_sel[i];
      bus.fwd_pending[i]       = ch_pending[i];
      chan_stall               = chan_stall | ch_stall[i];
    end
  end

`ifdef FWD_MD_STALL_EN
  localparam int CW = $clog2(DIV_LAT + 1);
  logic [CW-1:0] md_cnt;

  // A start (even while busy) reloads the full latency; otherwise count down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (bus.e_md_start) begin
      md_cnt <= bus.e_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign md_busy_int = (md_cnt != '0);
  assign md_stall    = bus.d_md & (md_busy_int | bus.e_md_start);
`else
  localparam int unused_lat = MULT_LAT + DIV_LAT;
  logic unused_md;
  assign unused_md   = ^{bus.d_md, bus.e_md_start, bus.e_md_div};
  assign md_busy_int = 1'b0;
  assign md_stall    = 1'b0;
`endif

  // Gated by reset_n so stall drops at once when reset asserts, even if the
  // mult/div start input is still high.
  assign stall_int   = reset_n & (chan_stall | md_stall);
  assign bus.stall   = stall_int;
  assign bus.md_busy = md_busy_int;

endmodule
